// File: rtl/strobe_sequencer_138.sv
// strobe_sequencer_138: round-robin arbiter that shares one 3-to-8 decoder
// among eight requesters, issuing one fixed-width strobe per grant with
// setup and recovery cycles around it.
module strobe_sequencer_138 #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] REQ,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       G1,
  output logic       G2A,
  output logic       G2B,
  output logic [7:0] GNT,
  output logic [7:0] ACK,
  output logic       BUSY
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    =
    CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  // Reject out-of-range timing parameters at elaboration.
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 16) begin : g_bad_strobe
    $error("strobe_sequencer_138: STROBE_CYCLES must be 1..16");
  end
  if (GAP_CYCLES > 15) begin : g_bad_gap
    $error("strobe_sequencer_138: GAP_CYCLES must be 0..15");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [N_REQ-1:0] ack_q,   ack_d;
  logic             en_q,    en_d;
  logic             g2n_q;
  logic             busy_q,  busy_d;

  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  // Round-robin search: nearest set request after LAST wins (descending
  // loop so the smallest offset is assigned last).
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last_q + IDX_W'(k);
      if (REQ[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    en_d    = en_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          sel_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = STROBE_LOAD;
        en_d    = 1'b1;
        if (STROBE_CYCLES == 1) ack_d = gnt_q;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          last_d = sel_q;
          en_d   = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = S_RECOVER;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) ack_d = gnt_q;
        end
      end
      S_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= IDX_W'(7);
      sel_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      g2n_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      g2n_q   <= ~en_d;
      busy_q  <= busy_d;
    end
  end

  assign A    = sel_q[0];
  assign B    = sel_q[1];
  assign C    = sel_q[2];
  assign G1   = en_q;
  assign G2A  = g2n_q;
  assign G2B  = g2n_q;
  assign GNT  = gnt_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_strobe_sequencer_138.sv
// Bench for strobe_sequencer_138: two instances (S=2,G=1 and S=1,G=0) share
// stimulus and are compared every cycle against a grant-phase model.
module tb_strobe_sequencer_138;

  logic       clk;
  logic       reset;
  logic [7:0] REQ;

  logic       a_a, b_a, c_a, g1_a, g2a_a, g2b_a, busy_a;
  logic [7:0] gnt_a, ack_a;
  logic       a_b, b_b, c_b, g1_b, g2a_b, g2b_b, busy_b;
  logic [7:0] gnt_b, ack_b;

  int n_checks;
  int n_fail;

  typedef struct {
    bit busy;
    int t;     // cycles since grant taken: 0 setup, 1..S strobe, then gap
    int win;
    int last;
    int sel;
  } mdl_t;

  mdl_t ma, mb;

  strobe_sequencer_138 #(.STROBE_CYCLES(2), .GAP_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .REQ(REQ),
    .A(a_a), .B(b_a), .C(c_a), .G1(g1_a), .G2A(g2a_a), .G2B(g2b_a),
    .GNT(gnt_a), .ACK(ack_a), .BUSY(busy_a)
  );

  strobe_sequencer_138 #(.STROBE_CYCLES(1), .GAP_CYCLES(0)) u_dut_s1 (
    .clk(clk), .reset(reset), .REQ(REQ),
    .A(a_b), .B(b_b), .C(c_b), .G1(g1_b), .G2A(g2a_b), .G2B(g2b_b),
    .GNT(gnt_b), .ACK(ack_b), .BUSY(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // One clock edge of the reference: arbitration in idle, phase count when busy.
  function automatic mdl_t mdl_step(input mdl_t m, input int s, input int g,
                                    input logic rst, input logic [7:0] req);
    mdl_t n = m;
    if (rst) begin
      n.busy = 1'b0; n.t = 0; n.last = 7; n.sel = 0; n.win = 0;
    end else if (!m.busy) begin
      if (req != 8'h00) begin
        for (int k = 8; k >= 1; k--)
          if (req[(m.last + k) % 8]) n.win = (m.last + k) % 8;
        n.busy = 1'b1; n.t = 0; n.sel = n.win; n.last = n.win;
      end
    end else begin
      n.t = m.t + 1;
      if (n.t > s + g) n.busy = 1'b0;
    end
    return n;
  endfunction

  task automatic check_dut(input string p, input mdl_t m, input int s,
                           input logic [7:0] gnt, input logic [7:0] ack,
                           input logic [2:0] sel, input logic g1,
                           input logic g2a, input logic g2b, input logic busy);
    logic [7:0] e_gnt, e_ack, y_got, y_exp;
    logic       e_en;
    e_gnt = 8'h00;
    if (m.busy) e_gnt[m.win] = 1'b1;
    e_en  = m.busy && (m.t >= 1) && (m.t <= s);
    e_ack = (m.busy && m.t == s) ? e_gnt : 8'h00;
    y_exp = 8'hFF;
    if (e_en) y_exp[m.sel] = 1'b0;
    y_got = 8'hFF;
    if (g1 && !g2a && !g2b) y_got[sel] = 1'b0;
    check({p, ".gnt"},  32'(gnt),  32'(e_gnt));
    check({p, ".ack"},  32'(ack),  32'(e_ack));
    check({p, ".sel"},  32'(sel),  32'(m.sel));
    check({p, ".g1"},   32'(g1),   32'(e_en));
    check({p, ".g2a"},  32'(g2a),  32'(!e_en));
    check({p, ".g2b"},  32'(g2b),  32'(!e_en));
    check({p, ".busy"}, 32'(busy), 32'(m.busy));
    check({p, ".y"},    32'(y_got), 32'(y_exp));
  endtask

  task automatic step();
    @(posedge clk);
    ma = mdl_step(ma, 2, 1, reset, REQ);
    mb = mdl_step(mb, 1, 0, reset, REQ);
    @(negedge clk);
    check_dut("s2g1", ma, 2, gnt_a, ack_a, {c_a, b_a, a_a},
              g1_a, g2a_a, g2b_a, busy_a);
    check_dut("s1g0", mb, 1, gnt_b, ack_b, {c_b, b_b, a_b},
              g1_b, g2a_b, g2b_b, busy_b);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    REQ      = 8'hFF;
    n_checks = 0;
    n_fail   = 0;
    ma = '{busy: 1'b0, t: 0, win: 0, last: 7, sel: 0};
    mb = ma;

    // Reset held with all requests asserted, then full rotation.
    run(3);
    reset = 1'b0;
    run(45);

    // Single pulsed request to requester 5.
    REQ = 8'h00;
    run(10);
    REQ = 8'h20;
    step();
    REQ = 8'h00;
    run(8);

    // Request withdrawn during setup still completes.
    REQ = 8'h08;
    step();
    REQ = 8'h00;
    run(8);

    // Reset in the first strobe cycle of requester 4, then 0 vs 4.
    REQ = 8'h10;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    REQ   = 8'h11;
    run(20);
    REQ = 8'h00;
    run(10);

    // Two requesters held: alternating grants.
    REQ = 8'h44;
    run(20);
    REQ = 8'h00;
    run(6);

    // Randomised requests with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) REQ = 8'h00;
      else REQ = 8'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    REQ   = 8'h00;
    run(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
